// File: rtl/caesar_stream_cipher.sv
// Caesar shift engine with per-frame key latch, ready/valid on both sides and a
// single output register. Byte mode shifts modulo 2^DATA_W; alpha mode rotates letters only.
module caesar_stream_cipher #(
   parameter int                DATA_W     = 8,
   parameter int                KEY_W      = 16,
   parameter int                ALPHA_ONLY = 0,
   parameter logic [DATA_W-1:0] TERM       = DATA_W'(8'hFA),
   parameter int                CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [KEY_W-1:0]  key,
   input  logic              mode_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              frame_done_o,
   output logic [CNT_W-1:0]  char_cnt_o
);

   generate
      if (ALPHA_ONLY != 0 && DATA_W != 8) begin : gIllegalCfg
         $error("caesar_stream_cipher: ALPHA_ONLY requires DATA_W == 8");
      end
   endgenerate

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   keyShift_q;
   logic [DATA_W-1:0]   data_q;
   logic                valid_q;
   logic                isTerm_q;
   logic [CNT_W-1:0]    cnt_q;

   logic [DATA_W-1:0]   shift_d;
   logic [DATA_W-1:0]   char_d;
   logic                accept;
   logic                isTermIn;

   // Alpha mode reduces the key modulo 26 once, so the per-character path only rotates.
   function automatic logic [DATA_W-1:0] keyToShift(input logic [KEY_W-1:0] k);
      if (ALPHA_ONLY != 0)
         keyToShift = DATA_W'(k % KEY_W'(26));
      else
         keyToShift = DATA_W'(k);
   endfunction

   function automatic logic [DATA_W-1:0] shiftChar(input logic [DATA_W-1:0] c,
                                                   input logic [DATA_W-1:0] s,
                                                   input logic              enc);
      logic [7:0] c8;
      logic [7:0] s8;
      logic [7:0] base;
      logic [7:0] idx;
      logic [7:0] rot;
      logic       isLetter;
      c8       = 8'(c);
      s8       = 8'(s);
      isLetter = 1'b1;
      base     = 8'h41;
      if (c8 >= 8'h41 && c8 <= 8'h5A)
         base = 8'h41;
      else if (c8 >= 8'h61 && c8 <= 8'h7A)
         base = 8'h61;
      else
         isLetter = 1'b0;
      idx = c8 - base;
      // Decrypt adds 26 first so the subtraction never goes negative.
      rot = enc ? (idx + s8) : (idx + 8'd26 - s8);
      if (rot >= 8'd26)
         rot = rot - 8'd26;
      if (ALPHA_ONLY == 0)
         shiftChar = enc ? (c + s) : (c - s);
      else if (isLetter)
         shiftChar = DATA_W'(base + rot);
      else
         shiftChar = c;
   endfunction

   assign ready_o      = ~valid_q | ready_i;
   assign accept       = valid_i & ready_o;
   assign isTermIn     = (data_i == TERM);
   assign data_o       = data_q;
   assign valid_o      = valid_q;
   assign char_cnt_o   = cnt_q;
   assign frame_done_o = valid_q & ready_i & isTerm_q;

   // The first character of a frame uses the live key so it needs no extra cycle.
   always_comb begin
      shift_d = keyShift_q;
      if (state_q == IDLE)
         shift_d = keyToShift(key);
      char_d = isTermIn ? TERM : shiftChar(data_i, shift_d, mode_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         keyShift_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         isTerm_q   <= 1'b0;
         cnt_q      <= '0;
      end else if (accept) begin
         valid_q  <= 1'b1;
         data_q   <= char_d;
         isTerm_q <= isTermIn;
         if (isTermIn) begin
            if (state_q == IDLE)
               cnt_q <= '0;
            state_q <= IDLE;
         end else if (state_q == IDLE) begin
            keyShift_q <= shift_d;
            cnt_q      <= CNT_W'(1);
            state_q    <= ACTIVE;
         end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_caesar_stream_cipher.sv
// Drives a byte-mode and an alpha-mode cipher with the same stream and checks both
// against a frame-level arithmetic reference model.
module tb_caesar_stream_cipher;

   localparam logic [7:0] TERM    = 8'hFA;
   localparam int         CNT_W   = 4;
   localparam int         CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        dataIn;
   logic              validIn;
   logic [15:0]       keyIn;
   logic              modeIn;
   logic              readyIn;

   logic              readyB, validB, doneB;
   logic [7:0]        dataB;
   logic [CNT_W-1:0]  cntB;
   logic              readyA, validA, doneA;
   logic [7:0]        dataA;
   logic [CNT_W-1:0]  cntA;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      int b;
      int a;
      bit term;
      int cnt;
   } expItem_t;

   expItem_t q[$];
   bit       inFrame   = 1'b0;
   int       frameKey  = 0;
   int       frameCnt  = 0;

   always #5 clk = ~clk;

   caesar_stream_cipher #(.DATA_W(8), .KEY_W(16), .ALPHA_ONLY(0), .TERM(TERM), .CNT_W(CNT_W)) uB (
      .clk(clk), .rst(rst), .data_i(dataIn), .valid_i(validIn), .ready_o(readyB),
      .key(keyIn), .mode_i(modeIn), .data_o(dataB), .valid_o(validB), .ready_i(readyIn),
      .frame_done_o(doneB), .char_cnt_o(cntB));

   caesar_stream_cipher #(.DATA_W(8), .KEY_W(16), .ALPHA_ONLY(1), .TERM(TERM), .CNT_W(CNT_W)) uA (
      .clk(clk), .rst(rst), .data_i(dataIn), .valid_i(validIn), .ready_o(readyA),
      .key(keyIn), .mode_i(modeIn), .data_o(dataA), .valid_o(validA), .ready_i(readyIn),
      .frame_done_o(doneA), .char_cnt_o(cntA));

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int byteRef(int c, int k, bit enc);
      int s = k % 256;
      return enc ? ((c + s) % 256) : ((c + 256 - s) % 256);
   endfunction

   function automatic int alphaRef(int c, int k, bit enc);
      int s = k % 26;
      int base;
      if (c >= 65 && c <= 90) base = 65;
      else if (c >= 97 && c <= 122) base = 97;
      else return c;
      return base + (enc ? ((c - base + s) % 26) : ((c - base - s + 26) % 26));
   endfunction

   function automatic void modelAccept(int d, int k, bit m);
      expItem_t it;
      if (d == int'(TERM)) begin
         if (!inFrame) frameCnt = 0;
         inFrame = 1'b0;
         it.b = d;
         it.a = d;
         it.term = 1'b1;
      end else begin
         if (!inFrame) begin
            frameKey = k;
            frameCnt = 1;
            inFrame  = 1'b1;
         end else if (frameCnt < CNT_MAX) begin
            frameCnt++;
         end
         it.b = byteRef(d, frameKey, m);
         it.a = alphaRef(d, frameKey, m);
         it.term = 1'b0;
      end
      it.cnt = frameCnt;
      q.push_back(it);
   endfunction

   // One clock cycle: inputs applied, outputs checked mid-cycle, model advanced after the edge.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [15:0] k,
                                input logic m, input logic r);
      bit full;
      bit xfer;
      bit accept;
      validIn = v; dataIn = d; keyIn = k; modeIn = m; readyIn = r;
      @(negedge clk); #1;
      full = (q.size() != 0);
      xfer = full && r;
      checkOutput("validB", validB, full);
      checkOutput("validA", validA, full);
      checkOutput("readyB", readyB, !full || r);
      checkOutput("readyA", readyA, !full || r);
      if (full) begin
         checkOutput("dataB", dataB, q[0].b);
         checkOutput("dataA", dataA, q[0].a);
         checkOutput("cntB", cntB, q[0].cnt);
         checkOutput("cntA", cntA, q[0].cnt);
      end
      checkOutput("doneB", doneB, xfer ? q[0].term : 1'b0);
      checkOutput("doneA", doneA, xfer ? q[0].term : 1'b0);
      accept = v && (!full || r);
      @(posedge clk); #1;
      if (xfer) void'(q.pop_front());
      if (accept) modelAccept(d, k, m);
   endtask

   task automatic doReset(input logic v);
      rst = 1'b1; validIn = v; dataIn = 8'h33; readyIn = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      inFrame  = 1'b0;
      frameCnt = 0;
      checkOutput("rstValid", validB, 1'b0);
      checkOutput("rstCnt", cntB, 0);
      checkOutput("rstCntA", cntA, 0);
   endtask

   task automatic drain();
      applyStimulus(1'b0, 8'h00, 16'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 16'h0, 1'b0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] d;
      int sel;
      rst = 1'b1; validIn = 1'b0; dataIn = '0; keyIn = '0; modeIn = 1'b0; readyIn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rstValidB", validB, 1'b0);
      checkOutput("rstDataB", dataB, 8'h00);
      checkOutput("rstDoneB", doneB, 1'b0);
      checkOutput("rstCntB", cntB, 0);

      // Byte shift by 3 in both directions inside one frame
      applyStimulus(1'b1, 8'h64, 16'd3, 1'b0, 1'b1);
      checkOutput("t1Dec", dataB, 8'h61);
      applyStimulus(1'b1, 8'h61, 16'd3, 1'b1, 1'b1);
      checkOutput("t1Enc", dataB, 8'h64);
      applyStimulus(1'b1, TERM, 16'd3, 1'b0, 1'b1);
      drain();

      // Byte wrap and key truncation
      applyStimulus(1'b1, 8'h02, 16'd5, 1'b0, 1'b1);
      checkOutput("t2WrapDec", dataB, 8'hFD);
      applyStimulus(1'b1, 8'hFE, 16'd5, 1'b1, 1'b1);
      checkOutput("t2WrapEnc", dataB, 8'h03);
      applyStimulus(1'b1, TERM, 16'd5, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h64, 16'h0103, 1'b0, 1'b1);
      checkOutput("t2KeyMod", dataB, 8'h61);
      applyStimulus(1'b1, TERM, 16'h0103, 1'b0, 1'b1);
      drain();

      // Alpha rotation with key 29
      applyStimulus(1'b1, 8'h61, 16'd29, 1'b0, 1'b1);
      checkOutput("t3Lower", dataA, 8'h78);
      applyStimulus(1'b1, 8'h43, 16'd29, 1'b0, 1'b1);
      checkOutput("t3Upper", dataA, 8'h5A);
      applyStimulus(1'b1, 8'h21, 16'd29, 1'b0, 1'b1);
      checkOutput("t3Other", dataA, 8'h21);
      applyStimulus(1'b1, TERM, 16'd29, 1'b0, 1'b1);
      drain();

      // Backpressure mid-stream
      applyStimulus(1'b1, 8'h41, 16'd2, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h42, 16'd2, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b1, 8'h43, 16'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h43, 16'd2, 1'b0, 1'b1);
      applyStimulus(1'b1, TERM, 16'd2, 1'b0, 1'b1);
      drain();

      // Key latched on first character only
      applyStimulus(1'b1, 8'h68, 16'd3, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h65, 16'd7, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h6C, 16'd7, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h6C, 16'd7, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h6F, 16'd7, 1'b0, 1'b1);
      checkOutput("t5LastChar", dataB, 8'h6C);
      applyStimulus(1'b1, TERM, 16'd7, 1'b0, 1'b1);
      checkOutput("t5TermData", dataB, TERM);
      checkOutput("t5Cnt", cntB, 5);
      applyStimulus(1'b1, 8'h68, 16'd7, 1'b0, 1'b1);
      checkOutput("t5NextKey", dataB, 8'h61);
      applyStimulus(1'b1, TERM, 16'd7, 1'b0, 1'b1);
      drain();

      // Reset while a character is stalled on the output
      applyStimulus(1'b1, 8'h41, 16'd9, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h42, 16'd9, 1'b0, 1'b0);
      doReset(1'b1);
      applyStimulus(1'b1, TERM, 16'd1, 1'b0, 1'b1);
      checkOutput("t6BareCnt", cntB, 0);
      applyStimulus(1'b1, 8'h42, 16'd1, 1'b0, 1'b1);
      checkOutput("t6NewKey", dataB, 8'h41);
      applyStimulus(1'b1, TERM, 16'd1, 1'b0, 1'b1);
      drain();

      // Long frame saturates the counter
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b1, 8'h30 + 8'(i), 16'd4, 1'b1, 1'b1);
      applyStimulus(1'b1, TERM, 16'd4, 1'b1, 1'b1);
      checkOutput("satCnt", cntB, CNT_MAX);
      drain();

      // Randomized traffic with occasional resets
      for (int i = 0; i < 500; i++) begin
         sel = int'($urandom_range(0, 7));
         if (sel == 0) d = TERM;
         else if (sel == 1) d = 8'h41 + 8'($urandom_range(0, 25));
         else if (sel == 2) d = 8'h61 + 8'($urandom_range(0, 25));
         else d = 8'($urandom);
         if ($urandom_range(0, 99) == 0)
            doReset(1'($urandom));
         else
            applyStimulus(1'($urandom_range(0, 3) != 0), d, 16'($urandom), 1'($urandom),
                          1'($urandom_range(0, 3) != 0));
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
